// File: rtl/layer_mem_pkg.sv
// layer_mem_pkg: shared constants and types for the layer result ping-pong store
package layer_mem_pkg;
  localparam int LAYER_DATA_W = 128;
  localparam int LAYER_MAP_H = 5;
  localparam int LAYER_MAP_W = 5;
  localparam int LAYER_ADDR_W = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int LAYER_ROW_W = idx_w(LAYER_MAP_H);
  localparam int LAYER_COL_W = idx_w(LAYER_MAP_W);
  typedef logic bank_sel_t;
endpackage

// File: rtl/layer_result_bank.sv
// layer_result_bank: one MAP_H x MAP_W word bank with synchronous write and registered read
module layer_result_bank
  import layer_mem_pkg::*;
#(
  parameter int DATA_W = LAYER_DATA_W,
  parameter int MAP_H = LAYER_MAP_H,
  parameter int MAP_W = LAYER_MAP_W,
  parameter int RW = idx_w(MAP_H),
  parameter int CW = idx_w(MAP_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [MAP_H][MAP_W];
  // rd_data returns to zero whenever this bank is not being read, so the top can OR both banks
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int r = 0; r < MAP_H; r++)
        for (int c = 0; c < MAP_W; c++)
          mem[r][c] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[wr_row][wr_col] <= wr_data;
      rd_data <= re ? mem[rd_row][rd_col] : '0;
    end
endmodule

// File: rtl/layer_result_pingpong_mem.sv
// layer_result_pingpong_mem: double-buffered feature-map store with frame-level bank handshakes
module layer_result_pingpong_mem
  import layer_mem_pkg::*;
#(
  parameter int DATA_W = LAYER_DATA_W,
  parameter int MAP_H = LAYER_MAP_H,
  parameter int MAP_W = LAYER_MAP_W,
  parameter int ADDR_W = LAYER_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_row,
  input  logic [ADDR_W-1:0] wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_row,
  input  logic [ADDR_W-1:0] rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_ready,
  input  logic              rd_release,
  output logic              drop_err,
  input  logic              err_clr
);
  localparam int RW = idx_w(MAP_H);
  localparam int CW = idx_w(MAP_W);
  logic [1:0] full, full_n;
  bank_sel_t wb, rb;
  logic wr_in, rd_in, wr_acc, wr_done, rd_fire, rel, drop;
  logic [DATA_W-1:0] rd_q [2];
  assign wr_ready = !full[wb];
  assign rd_ready = full[rb];
  // full-width compares so large coordinates never alias into the map
  assign wr_in = (wr_row < ADDR_W'(MAP_H)) && (wr_col < ADDR_W'(MAP_W));
  assign rd_in = (rd_row < ADDR_W'(MAP_H)) && (rd_col < ADDR_W'(MAP_W));
  assign wr_acc = wr_en && wr_ready && wr_in;
  assign wr_done = wr_acc && wr_last;
  assign drop = wr_en && !wr_acc;
  assign rd_fire = rd_en && rd_ready;
  assign rel = rd_release && rd_ready;
  assign rd_data = rd_q[0] | rd_q[1];
  always_comb begin
    full_n = full;
    if (wr_done) full_n[wb] = 1'b1;
    if (rel) full_n[rb] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      rd_valid <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      full <= full_n;
      wb <= wb ^ wr_done;
      rb <= rb ^ rel;
      rd_valid <= rd_fire;
      drop_err <= err_clr ? 1'b0 : (drop_err | drop);
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    layer_result_bank #(
      .DATA_W(DATA_W),
      .MAP_H(MAP_H),
      .MAP_W(MAP_W),
      .RW(RW),
      .CW(CW)
    ) u_bank (
      .clk(clk),
      .rst(rst),
      .we(wr_acc && (wb == bank_sel_t'(b))),
      .wr_row(wr_row[RW-1:0]),
      .wr_col(wr_col[CW-1:0]),
      .wr_data(wr_data),
      .re(rd_fire && rd_in && (rb == bank_sel_t'(b))),
      .rd_row(rd_row[RW-1:0]),
      .rd_col(rd_col[CW-1:0]),
      .rd_data(rd_q[b])
    );
  end
endmodule

// File: doc/layer_result_pingpong_mem.md
# layer_result_pingpong_mem

Parametrised, double-buffered (ping-pong) feature-map store between a convolution/pooling layer's output stage and the next layer's weight-multiply input stage. The producer fills one bank of an H×W map of packed channel words while the consumer reads the other bank. Bank ownership is exchanged by frame-level handshakes. Out-of-range and unready writes are trapped rather than silently aliased.

## Interface
- DATA_W, 128, packed channel word width (channels × per-channel width)
- MAP_H, 5, map rows per bank
- MAP_W, 5, map columns per bank
- ADDR_W, 16, row/column address port width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- wr_row, wr_col  in  ADDR_W  write coordinates
- wr_data  in  DATA_W  write word
- wr_last  in  1  qualifies wr_en: final word of frame
- wr_ready  out  1  write bank is free to fill
- rd_en  in  1  read request
- rd_row, rd_col  in  ADDR_W  read coordinates
- rd_data  out  DATA_W  read word, registered
- rd_valid  out  1  rd_data corresponds to a request one cycle earlier
- rd_ready  out  1  read bank holds a complete frame
- rd_release  in  1  consumer finished with the read bank
- drop_err  out  1  sticky: a write was discarded
- err_clr  in  1  clears drop_err

## Operation
- Two banks, each MAP_H×MAP_W words. There is one full flag per bank, plus a write pointer wb and a read pointer rb (1 bit each).
- wr_ready = !full[wb]; rd_ready = full[rb].
- Write accepted when wr_en && wr_ready && wr_row<MAP_H && wr_col<MAP_W. Compares use all ADDR_W bits, with no truncation or aliasing.
- Accepted write stores wr_data at bank[wb][wr_row][wr_col].
- Accepted write with wr_last sets full[wb] and toggles wb.
- wr_en with !wr_ready, or with an out-of-range address, discards the word and sets drop_err.
  - A discarded wr_last does not complete the frame.
- Read: if rd_en && rd_ready, the word at bank[rb][rd_row][rd_col] appears on rd_data next cycle with rd_valid=1. An out-of-range address returns 0 with rd_valid=1.
- rd_en with !rd_ready: rd_valid=0 and rd_data=0 next cycle.
- rd_release with rd_ready clears full[rb] and toggles rb. rd_release without rd_ready is ignored.
- Simultaneous wr_last completion and rd_release on different banks: both take effect in the same cycle.
  - The same bank cannot be involved in both, because wr_ready and rd_ready are mutually exclusive when wb==rb.
- err_clr has priority over a same-cycle drop. drop_err reads 0 after that edge.
- Bank contents persist across release and are overwritten by the next fill. Unwritten locations keep stale data.

## Timing
- Reset values:
  - wb=rb=0, both full flags 0, all bank words 0
  - rd_data=0, rd_valid=0, wr_ready=1, rd_ready=0, drop_err=0
- Read latency: 1 cycle, request at edge N, data valid after edge N, sampled at edge N+1. Back-to-back reads give one word per cycle.
- wr_last accepted at edge N: full updates at N. The same bank's rd_ready rises in the cycle after N if rb points to it.
- rd_release at edge N: rd_ready reflects the next bank after N. wr_ready may rise in the same cycle.
- The read issued in the same cycle as rd_release still returns data from the released bank.
- Reset mid-frame discards the partial frame and returns both banks to empty. A pending rd_valid is forced to 0 immediately.
- Steady-state throughput is one write and one read per cycle with no stalls while the consumer releases before the producer completes the next frame.

## Structure
- Package layer_mem_pkg holds the following shared constants:
  - default DATA_W, MAP_H and MAP_W per layer
  - clog2-derived index widths
  - the bank-select bit type
- Sub-module layer_result_bank: one MAP_H×MAP_W bank with async-reset storage, synchronous write and a registered-read mux. The top instantiates two of them and owns the pointers, full flags, range checks and error logic.

## Test plan
- Basic frame, fill then read:
  - Reset, then fill bank 0 with word = row*16+col for rows 0–4 and cols 0–4, wr_last on (4,4).
  - Expect rd_ready=1 and wr_ready=1, then read (2,3) returning 0x23 one cycle later.
- Ping-pong overlap:
  - Fill frame A, then fill frame B while reading frame A.
  - Release A: rd_ready stays 1 and reads return B's values. A third frame's writes are accepted into bank 0.
- Back-pressure:
  - Fill both banks without release.
  - Expect wr_ready=0. A further write to (0,0) of 0xFF is dropped, drop_err=1, and bank contents are unchanged.
- Out of range:
  - Write to (5,0) and to (0x0100,0).
  - Expect both dropped and no alias into (0,0), with drop_err=1.
  - A read of (7,7) returns 0 with rd_valid=1.
  - err_clr returns drop_err to 0.
- Simultaneous events:
  - In one cycle, issue wr_last to bank 1 and rd_release of bank 0.
  - Expect rb=1, rd_ready=1 and wr_ready=1 next cycle.
- Reset mid-operation:
  - Assert rst halfway through a fill with a read outstanding.
  - Expect rd_valid=0 immediately, wr_ready=1, rd_ready=0, and a read of any location after re-fill start shows 0 in unwritten cells.
